// File: rtl/nes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nes_pkg
//  Description : Shared definitions for the NES controller poller and its
//                consumers: FSM state codes, button bit positions and the
//                serial-order-to-button remap.
//  Revision    : 1.0 - initial release
// ============================================================================
package nes_pkg;

  // Poller FSM state codes
  typedef logic [2:0] nes_state_t;
  localparam nes_state_t ST_IDLE  = 3'd0;
  localparam nes_state_t ST_LATCH = 3'd1;
  localparam nes_state_t ST_LOW   = 3'd2;
  localparam nes_state_t ST_HIGH  = 3'd3;
  localparam nes_state_t ST_DONE  = 3'd4;

  // Bit positions of each button inside o_buttons
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_LEFT   = 2;
  localparam int BTN_RIGHT  = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_SELECT = 5;
  localparam int BTN_A      = 6;
  localparam int BTN_B      = 7;

  // Entry [i] gives the o_buttons position of the i-th bit shifted out of the
  // controller (shift order: A, B, Select, Start, Up, Down, Left, Right).
  localparam logic [7:0][2:0] SERIAL_TO_BTN = {
    3'(BTN_RIGHT), 3'(BTN_LEFT),   3'(BTN_DOWN), 3'(BTN_UP),
    3'(BTN_START), 3'(BTN_SELECT), 3'(BTN_B),    3'(BTN_A)
  };

  // Reorder a frame of serial samples into o_buttons layout
  function automatic logic [7:0] remap_buttons(input logic [7:0] serial);
    logic [7:0] btn;
    btn = 8'h00;
    for (int i = 0; i < 8; i++) begin
      btn[SERIAL_TO_BTN[i]] = serial[i];
    end
    return btn;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nes_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : nes_phase_timer
//  Description : Loadable down-counter timing the LATCH/LOW/HIGH phases.
//                Loading N-1 keeps o_done low for N-1 cycles, so a phase that
//                leaves on o_done lasts exactly N cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_phase_timer #(
  parameter int WIDTH = 10
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_done
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: load has priority, otherwise count down and stick at zero
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_done = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/nes_poller.sv
`default_nettype none
// ============================================================================
//  Module      : nes_poller
//  Description : Periodically polls an NES controller: latch strobe, eight
//                shift-clock pulses, samples the active-low serial data and
//                publishes the remapped button flags with a one-cycle valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module nes_poller #(
  parameter int CLK_HZ       = 50000000,
  parameter int POLL_CYCLES  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_nes_data,
  output logic       o_nes_latch,
  output logic       o_nes_clk,
  output logic [7:0] o_buttons,
  output logic       o_valid
);
  import nes_pkg::*;

  localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int TMAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX + 1) : 1;

  localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] LATCH_LOAD = TW'(LATCH_CYCLES - 1);
  localparam logic [TW-1:0] HALF_LOAD  = TW'(HALF_CYCLES - 1);

  // CLK_HZ documents the timing base; all durations are given in cycles.
  logic unused_clk_hz;
  assign unused_clk_hz = ^CLK_HZ;

  logic            sync1_q, sync2_q;
  logic [PW-1:0]   poll_cnt_q, poll_cnt_d;
  logic            poll_tick;
  nes_state_t      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            latch_q, latch_d;
  logic            nclk_q, nclk_d;
  logic [7:0]      buttons_q, buttons_d;
  logic            valid_q, valid_d;
  logic            tmr_load;
  logic [TW-1:0]   tmr_load_val;
  logic            tmr_done;

  // Two-flop synchronizer on the controller data; idles high (released line)
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= i_nes_data;
      sync2_q <= sync1_q;
    end
  end

  // Free-running poll counter; tick on the wrap cycle
  always_comb begin
    poll_tick  = (poll_cnt_q == POLL_LAST);
    poll_cnt_d = poll_tick ? '0 : poll_cnt_q + PW'(1);
  end

  nes_phase_timer #(
    .WIDTH (TW)
  ) u_phase_timer (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_load     (tmr_load),
    .i_load_val (tmr_load_val),
    .o_done     (tmr_done)
  );

  // Frame sequencing, sampling and next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (poll_tick) begin
          state_d      = ST_LATCH;
          shift_d      = 8'h00;
          tmr_load     = 1'b1;
          tmr_load_val = LATCH_LOAD;
        end
      end
      ST_LATCH: begin
        if (tmr_done) begin
          state_d      = ST_LOW;
          idx_d        = 3'd0;
          tmr_load     = 1'b1;
          tmr_load_val = HALF_LOAD;
        end
      end
      ST_LOW: begin
        if (tmr_done) begin
          shift_d[idx_q] = ~sync2_q;
          state_d        = ST_HIGH;
          tmr_load       = 1'b1;
          tmr_load_val   = HALF_LOAD;
        end
      end
      ST_HIGH: begin
        if (tmr_done) begin
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_LOW;
            idx_d        = idx_q + 3'd1;
            tmr_load     = 1'b1;
            tmr_load_val = HALF_LOAD;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are clean flop outputs
    // aligned with the state they belong to.
    latch_d   = (state_d == ST_LATCH);
    nclk_d    = (state_d == ST_HIGH);
    valid_d   = (state_d == ST_DONE);
    buttons_d = (state_d == ST_DONE) ? remap_buttons(shift_q) : buttons_q;
  end

  // State, counters and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      poll_cnt_q <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      shift_q    <= 8'h00;
      latch_q    <= 1'b0;
      nclk_q     <= 1'b0;
      buttons_q  <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      latch_q    <= latch_d;
      nclk_q     <= nclk_d;
      buttons_q  <= buttons_d;
      valid_q    <= valid_d;
    end
  end

  assign o_nes_latch = latch_q;
  assign o_nes_clk   = nclk_q;
  assign o_buttons   = buttons_q;
  assign o_valid     = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_nes_poller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nes_poller
//  Description : Directed self-checking bench for nes_poller with shortened
//                timing, a behavioural controller model and a second instance
//                whose poll period is shorter than a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nes_poller;

  localparam int LAT   = 12;
  localparam int HALF  = 6;
  localparam int POLL  = 400;
  localparam int POLL2 = 80;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rst2_n = 1'b0;
  logic [7:0] pressed = 8'h00;   // serial order: bit i = i-th shifted button
  logic [3:0] cidx = 4'd8;
  logic       prev_nclk = 1'b0;
  logic       nes_data;

  logic       latch, nclk, valid;
  logic [7:0] buttons;
  logic       latch2, nclk2, valid2;
  logic [7:0] buttons2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  // Controller model: latch reloads, each shift-clock rise advances one bit
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    prev_nclk <= nclk;
    if (latch) cidx <= 4'd0;
    else if (nclk && !prev_nclk && cidx < 4'd8) cidx <= cidx + 4'd1;
  end
  assign nes_data = (cidx < 4'd8) ? ~pressed[cidx[2:0]] : 1'b1;

  nes_poller #(
    .CLK_HZ(50000000), .POLL_CYCLES(POLL), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_nes_data(nes_data),
    .o_nes_latch(latch), .o_nes_clk(nclk), .o_buttons(buttons), .o_valid(valid)
  );

  nes_poller #(
    .CLK_HZ(50000000), .POLL_CYCLES(POLL2), .LATCH_CYCLES(LAT), .HALF_CYCLES(HALF)
  ) dut2 (
    .i_clk(clk), .i_reset_n(rst2_n), .i_nes_data(1'b1),
    .o_nes_latch(latch2), .o_nes_clk(nclk2), .o_buttons(buttons2), .o_valid(valid2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for a latch rise, then follow the frame to its valid pulse
  task automatic run_frame(input int tog_at, input logic [7:0] tog_pat,
                           output int wait_n, output int pre_valids,
                           output int lat, output int rises, output int hi,
                           output int lo, output int vcyc, output logic [7:0] btn,
                           output bit changed, output bit vnext, output bit tmo);
    logic [7:0] start_btn;
    logic       pclk;
    int         n;
    wait_n = 0; pre_valids = 0; lat = 0; rises = 0; hi = 0; lo = 0;
    vcyc = 0; btn = 8'h00; changed = 0; vnext = 0; tmo = 0;
    while (!latch && wait_n < 2000) begin
      @(negedge clk);
      wait_n++;
      if (valid) pre_valids++;
    end
    if (!latch) begin
      tmo = 1;
      return;
    end
    start_btn = buttons;
    pclk = 1'b0;
    n = 0;
    while (!valid && n < 1000) begin
      if (latch) lat++;
      else if (nclk) begin
        hi++;
        if (!pclk) begin
          rises++;
          if (rises == tog_at) pressed = tog_pat;
        end
      end else lo++;
      if (buttons !== start_btn) changed = 1;
      pclk = nclk;
      @(negedge clk);
      n++;
    end
    if (!valid) begin
      tmo = 1;
      return;
    end
    btn  = buttons;
    vcyc = cyc;
    @(negedge clk);
    vnext = valid;
  endtask

  initial begin
    int wn, pv, lt, rs, hc, lc, vc, vc_prev, bad, k, first, last, nr, lh, nv;
    logic [7:0] b;
    bit ch, vn, to;
    logic pl;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_latch",   32'(latch),   32'h0);
    check("rst_nes_clk", 32'(nclk),    32'h0);
    check("rst_buttons", 32'(buttons), 32'h00);
    check("rst_valid",   32'(valid),   32'h0);
    rst_n = 1'b1;

    // Frame 1: nothing pressed, full timing check
    run_frame(0, 8'h00, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("f1_timeout",     32'(to), 32'h0);
    check("f1_first_latch", 32'(wn), 32'(POLL));
    check("f1_latch_width", 32'(lt), 32'(LAT));
    check("f1_clk_pulses",  32'(rs), 32'd8);
    check("f1_clk_high",    32'(hc), 32'(8 * HALF));
    check("f1_clk_low",     32'(lc), 32'(8 * HALF));
    check("f1_buttons",     32'(b),  32'h00);
    check("f1_valid_1cyc",  32'(vn), 32'h0);
    vc_prev = vc;

    // Frame 2: A and Up pressed
    pressed = 8'b0001_0001;
    run_frame(0, 8'h00, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("f2_timeout",    32'(to), 32'h0);
    check("f2_buttons",    32'(b),  32'h41);
    check("f2_period",     32'(vc - vc_prev), 32'(POLL));
    check("f2_held",       32'(ch), 32'h0);

    // Frame 3: everything pressed
    pressed = 8'hFF;
    run_frame(0, 8'h00, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("f3_timeout", 32'(to), 32'h0);
    check("f3_buttons", 32'(b),  32'hFF);

    // Frame 4: everything released; FF must hold until this frame's valid
    pressed = 8'h00;
    run_frame(0, 8'h00, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("f4_timeout",  32'(to), 32'h0);
    check("f4_held",     32'(ch), 32'h0);
    check("f4_buttons",  32'(b),  32'h00);

    // Frame 5: pattern changes during HIGH of bit 3
    pressed = 8'hA5;
    run_frame(4, 8'h5A, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("f5_timeout", 32'(to), 32'h0);
    check("f5_held",    32'(ch), 32'h0);
    check("f5_buttons", 32'(b),  32'h65);

    // Reset during HIGH of bit 5
    k = 0;
    while (!latch && k < 2000) begin @(negedge clk); k++; end
    nr = 0; pl = 1'b0; k = 0;
    while (nr < 6 && k < 1000) begin
      if (nclk && !pl) nr++;
      pl = nclk;
      if (nr < 6) begin @(negedge clk); k++; end
    end
    check("r_reached_bit5", 32'(nr), 32'd6);
    #2;
    check("r_clk_high_pre", 32'(nclk), 32'h1);
    rst_n = 1'b0;
    #1;
    check("r_async_latch",   32'(latch),   32'h0);
    check("r_async_nes_clk", 32'(nclk),    32'h0);
    check("r_async_buttons", 32'(buttons), 32'h00);
    check("r_async_valid",   32'(valid),   32'h0);
    repeat (3) @(negedge clk);
    pressed = 8'h01;
    rst_n = 1'b1;
    run_frame(0, 8'h00, wn, pv, lt, rs, hc, lc, vc, b, ch, vn, to);
    check("r_timeout",      32'(to), 32'h0);
    check("r_first_latch",  32'(wn), 32'(POLL));
    check("r_no_valid",     32'(pv), 32'h0);
    check("r_buttons",      32'(b),  32'h40);

    // Poll period shorter than a frame: ticks inside a frame are dropped
    @(negedge clk);
    rst2_n = 1'b1;
    first = 0; last = 0; nr = 0; bad = 0; lh = 0; nv = 0; pl = 1'b0;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (latch2) lh++;
      if (valid2) nv++;
      if (latch2 && !pl) begin
        nr++;
        if (nr == 1) first = i;
        else if (i - last != 2 * POLL2) bad++;
        last = i;
      end
      pl = latch2;
    end
    check("s_first_latch", 32'(first), 32'(POLL2));
    check("s_latch_rises", 32'(nr),    32'd4);
    check("s_interval",    32'(bad),   32'd0);
    check("s_latch_high",  32'(lh),    32'(4 * LAT));
    check("s_valids",      32'(nv),    32'd4);
    check("s_buttons",     32'(buttons2), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nes_poller.md
NES_POLLER -- requirements
Module: nes_poller

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- CLK_HZ, 50000000, input clock frequency.
- POLL_CYCLES, 833333, clocks between poll starts (60 Hz).
- LATCH_CYCLES, 600, latch high time (12 us).
- HALF_CYCLES, 300, NES clock half-period (6 us).
REQ-002 The block SHALL have ports (name, direction, width, meaning), clock and reset first:
- i_clk, in, 1, 50 MHz clock.
- i_reset_n, in, 1, reset, asynchronous, active-low.
- i_nes_data, in, 1, controller serial data, active-low.
- o_nes_latch, out, 1, controller latch strobe.
- o_nes_clk, out, 1, controller shift clock.
- o_buttons, out, 8, pressed flags, 1 = pressed: [0]up [1]down [2]left [3]right [4]start [5]select [6]a [7]b.
- o_valid, out, 1, one-cycle pulse when o_buttons is updated.
REQ-003 There SHALL be one clock; reset SHALL be asynchronous and active-low on i_reset_n.

Function
REQ-004 i_nes_data SHALL pass through a 2-flop synchronizer before use; all sampling SHALL use the synchronized value.
REQ-005 A free-running poll counter SHALL count 0..POLL_CYCLES-1 and wrap to 0. It SHALL assert a poll tick on the wrap cycle. The first tick SHALL occur POLL_CYCLES clocks after reset release.
REQ-006 The FSM states SHALL be IDLE, LATCH, LOW, HIGH and DONE.
REQ-007 IDLE -> LATCH on a poll tick. In LATCH, o_nes_latch=1 for exactly LATCH_CYCLES clocks, then -> LOW with bit index 0.
REQ-008 In LOW, o_nes_clk=0 for HALF_CYCLES clocks. On the last LOW cycle the FSM SHALL sample the inverted synchronized data into shift bit[index], then -> HIGH.
REQ-009 In HIGH, o_nes_clk=1 for HALF_CYCLES clocks. Then:
- -> LOW with index+1 if index<7;
- otherwise -> DONE.
A frame therefore has exactly 8 clock pulses.
REQ-010 The serial sample order SHALL be A, B, Select, Start, Up, Down, Left, Right (index 0..7).
REQ-011 DONE SHALL last one cycle. In that cycle it SHALL remap the samples onto o_buttons per REQ-002, assert o_valid, and -> IDLE. This gives one valid pulse per frame.
REQ-012 Poll ticks arriving outside IDLE SHALL be ignored, not queued. A frame (600+8*600 = 5400 clocks) is shorter than the poll period, so with defaults no tick is ever dropped.
REQ-013 o_buttons SHALL hold its last value between DONE cycles. Partial frames SHALL never be visible on o_buttons.
REQ-014 o_nes_latch and o_nes_clk SHALL be registered outputs, glitch-free. They SHALL be 0 in IDLE and DONE.
REQ-015 A floating or disconnected controller (data stuck 1) SHALL yield o_buttons=8'h00.

Reset
REQ-016 While i_reset_n=0:
- state=IDLE;
- poll counter, phase counter, bit index and shift register = 0;
- o_nes_latch=0, o_nes_clk=0, o_buttons=8'h00, o_valid=0;
- synchronizer flops = 1 (released/idle line).
REQ-017 Reset asserted mid-frame SHALL abort the frame immediately with no o_valid pulse. After release, polling SHALL restart per REQ-005.

Structure
REQ-018 A shared package nes_pkg SHALL hold:
- the state enum;
- the button index constants (UP=0 .. B=7);
- the serial-order-to-output remap table.
The final_project top and the NES display logic SHALL also use nes_pkg.
REQ-019 One sub-module, nes_phase_timer, SHALL implement the loadable down-counter used for LATCH/LOW/HIGH durations (load value, done flag). The poll counter SHALL stay inline.

Verification
REQ-020 Verification scenarios (stimulus -> required response):
- Run with defaults, controller model with nothing pressed (data=1 throughout) -> latch high exactly 600 clocks; 8 clock pulses, each 300 low / 300 high; o_valid once per 833333 clocks; o_buttons=8'h00.
- Model drives A and Up pressed (serial bits 0 and 4 low) -> o_buttons=8'b0100_0001 on the o_valid cycle.
- All eight buttons pressed -> o_buttons=8'hFF. Next frame with all released -> 8'h00, updated only on that frame's o_valid.
- Toggle data mid-frame after bit 3 is sampled -> o_buttons unchanged until DONE; the captured value reflects each bit's value at its own sample point.
- Assert i_reset_n=0 during HIGH of bit 5 -> latch/clk/o_buttons go 0 asynchronously; no o_valid; first new latch rise POLL_CYCLES clocks after release.
- Override POLL_CYCLES=4000 (shorter than a 5400-clock frame) -> ticks during the frame are ignored; frames start only from IDLE; never an overlapping latch.
